// File: rtl/avwb_slave_bridge.sv
// Avalon-MM slave to Wishbone classic master bridge with a sticky bus-error flag and a registered irq.
// Optional ack/err timeout abort is compiled in with the AVWB_TIMEOUT_EN macro.
module avwb_slave_bridge #(
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   s_address,
  input  logic            s_chipselect,
  input  logic            s_read,
  input  logic            s_write,
  input  logic [DW/8-1:0] s_byteenable,
  input  logic [DW-1:0]   s_writedata,
  output logic [DW-1:0]   s_readdata,
  output logic            s_waitrequest,
  output logic            s_irq,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_int_i,
  output logic            bus_err,
  input  logic            bus_err_clr
);

  typedef enum logic [1:0] {IDLE = 2'd0, CYC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              irq_q, irq_d;
  logic              err_set;
  logic              tmo_hit;
  logic              req;

  assign req = s_chipselect & (s_read | s_write);

`ifdef AVWB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter holds zero outside a cycle, so it starts from zero on every entry to CYC.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == CYC) tmo_cnt_d = tmo_cnt_q + CW'(1);
  end

  assign tmo_hit = (state_q == CYC) &&
                   (({1'b0, tmo_cnt_q} + (CW+1)'(1)) == (CW+1)'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // Without the timeout build the limit is irrelevant and this never fires.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rdata_d = rdata_q;
    err_set = 1'b0;
    irq_d   = wb_int_i;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d   = s_address;
          dat_d   = s_writedata;
          sel_d   = s_byteenable;
          we_d    = s_write;
          cyc_d   = 1'b1;
          state_d = CYC;
        end
      end
      CYC: begin
        // Error (or timeout) outranks a simultaneous ack.
        if (wb_err_i || tmo_hit) begin
          rdata_d = '1;
          err_set = 1'b1;
          cyc_d   = 1'b0;
          state_d = RESP;
        end else if (wb_ack_i) begin
          if (!we_q) rdata_d = wb_dat_i;
          cyc_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bus_err_d = err_set ? 1'b1 : (bus_err_clr ? 1'b0 : bus_err_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      irq_q     <= irq_d;
    end
  end

  // The Avalon stall is released only in RESP, one cycle after the Wishbone handshake.
  assign s_waitrequest = req & (state_q != RESP);
  assign s_readdata    = rdata_q;
  assign s_irq         = irq_q;
  assign bus_err       = bus_err_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;

endmodule
